// File: rtl/fetch_stage.sv
// fetch_stage: PC-owning instruction fetch with redirect, decode backpressure
// and opcode+immediate pairing into one registered instruction per transfer.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 16,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit                IMM_EN   = 1'b1,
    parameter int                IMM_BIT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_imm,
    output logic               out_has_imm,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_next_pc
);
    typedef enum logic {OP, IMM} state_t;
    state_t              state;
    logic [ADDR_W-1:0]   pc, hold_pc, pc_inc;
    logic [INSTR_W-1:0]  hold_instr;
    logic                slot_free, is_two;
    assign imem_addr = pc;
    assign pc_inc    = pc + ADDR_W'(PC_STEP);
    assign slot_free = !out_valid || out_ready;
    assign is_two    = IMM_EN && imem_data[IMM_BIT];
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            state       <= OP;
            hold_instr  <= '0;
            hold_pc     <= '0;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_imm     <= '0;
            out_has_imm <= 1'b0;
            out_pc      <= '0;
            out_next_pc <= '0;
        end else if (redirect_valid) begin
            pc         <= redirect_pc;
            state      <= OP;
            hold_instr <= '0;
            hold_pc    <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (!stall) begin
                // The opcode half of a pair is captured even while decode is blocked
                if (state == OP && is_two) begin
                    hold_instr <= imem_data;
                    hold_pc    <= pc;
                    pc         <= pc_inc;
                    state      <= IMM;
                end else if (slot_free) begin
                    out_valid   <= 1'b1;
                    out_instr   <= state == IMM ? hold_instr : imem_data;
                    out_imm     <= state == IMM ? imem_data : '0;
                    out_has_imm <= state == IMM;
                    out_pc      <= state == IMM ? hold_pc : pc;
                    out_next_pc <= pc_inc;
                    pc          <= pc_inc;
                    state       <= OP;
                end
            end
        end
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch stage with decode-side handshake, branch/interrupt redirect and two-word (opcode + immediate) instruction assembly. It sits between the instruction memory and the fetch/decode pipeline register. It owns the PC, drives the instruction-memory address, and delivers one assembled instruction per accepted transfer to decode. It replaces the single-word, always-advancing fetch path, which had no redirect, no backpressure and no immediate pairing.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 16, instruction and immediate word width
- PC_STEP, 1, PC increment per memory word, in address units
- RESET_PC, 0, PC value loaded on reset
- IMM_EN, 1, enables two-word instruction assembly; 0 means every word is a complete instruction
- IMM_BIT, 15, bit of the opcode word that flags a following immediate word

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; freezes PC and FSM
- redirect_valid  in  1  branch/interrupt/return redirect request
- redirect_pc  in  ADDR_W  redirect target
- imem_addr  out  ADDR_W  instruction memory address; equals the PC register
- imem_data  in  INSTR_W  memory word at imem_addr, combinational, same cycle
- out_valid  out  1  assembled instruction present
- out_ready  in  1  decode accepts; a transfer occurs on out_valid && out_ready
- out_instr  out  INSTR_W  opcode word
- out_imm  out  INSTR_W  immediate word; 0 when out_has_imm=0
- out_has_imm  out  1  instruction carried an immediate
- out_pc  out  ADDR_W  address of the opcode word
- out_next_pc  out  ADDR_W  address following the whole instruction

## Operation
- **State:** pc, FSM {OP, IMM}, hold_instr and hold_pc, and the output register set.
- **Flags:** `slot_free = !out_valid || out_ready`. `is_two = IMM_EN && imem_data[IMM_BIT]`.
- **Priority 1, rst:** pc=RESET_PC, FSM=OP, out_valid=0, all other outputs and hold registers 0.
- **Priority 2, redirect_valid:** this overrides stall and out_ready.
  - pc=redirect_pc, FSM=OP, out_valid=0, hold discarded.
  - The word on imem_data this cycle is dropped.
- **Priority 3, stall=1:** nothing changes.
  - Outputs hold.
  - out_valid stays asserted if already set; a transfer with out_ready=1 still completes and clears out_valid.
- **OP state, is_two=1 (needs only !stall):**
  - hold_instr=imem_data, hold_pc=pc.
  - pc += PC_STEP, FSM=IMM.
  - The output register is untouched, apart from being cleared on a completed transfer.
- **OP state, is_two=0, slot_free:**
  - Load the output register: out_instr=imem_data, out_imm=0, out_has_imm=0, out_pc=pc, out_next_pc=pc+PC_STEP.
  - out_valid=1, pc += PC_STEP.
- **IMM state, slot_free:**
  - Load the output register: out_instr=hold_instr, out_imm=imem_data, out_has_imm=1, out_pc=hold_pc, out_next_pc=pc+PC_STEP.
  - out_valid=1, pc += PC_STEP, FSM=OP.
- **No slot free:** pc, FSM and outputs hold, and the same address is re-presented.
- **Clearing out_valid:** if a transfer completes and no new load happens that cycle, out_valid=0.
- **Arithmetic:** all PC arithmetic is modulo 2^ADDR_W. An instruction straddling the top address wraps to 0 and out_next_pc wraps the same way.

## Timing
- imem_addr is valid from the clock edge; no combinational path from any input to imem_addr.
- Latency, single-word instruction: presented at cycle N, out_valid in cycle N+1.
- Latency, two-word instruction: opcode at N, immediate at N+1, out_valid in N+2.
- Throughput with out_ready=1 and no stall: 1 single-word instruction per cycle, 1 two-word instruction per 2 cycles.
- Redirect in cycle N: imem_addr=redirect_pc in N+1, and the first out_valid for the new stream is in N+2 at the earliest.
- Outputs are fully registered and must stay stable while out_valid && !out_ready.

## Test plan
- **Reset and single-word stream:** rst for 2 cycles, RESET_PC=0, memory words 0x0001, 0x0002, 0x0003, out_ready=1.
  - Required: imem_addr 0,1,2,… and out_pc 0,1,2 with out_instr 0x0001..0x0003, one per cycle.
  - Required: out_valid=0 in the first cycle after reset.
- **Two-word instruction:** mem[4]=0x8005 (bit15 set), mem[5]=0x1234.
  - Required: one transfer with out_instr=0x8005, out_imm=0x1234, out_has_imm=1, out_pc=4, out_next_pc=6.
  - Required: no output for address 5 alone.
- **Backpressure:** out_ready=0 for 3 cycles while out_valid=1.
  - Required: outputs and imem_addr frozen.
  - Required: after out_ready rises, no instruction is lost or duplicated.
- **Stall plus redirect:** stall=1 and redirect_valid=1 with redirect_pc=0x40 in the same cycle, FSM in IMM.
  - Required: next cycle imem_addr=0x40, out_valid=0, and the held opcode is never emitted.
- **Wrap-around:** ADDR_W=8, PC=0xFF with a two-word opcode.
  - Required: the immediate is fetched from 0x00, out_pc=0xFF, out_next_pc=0x01.
- **Mid-operation reset:** assert rst while in IMM with out_valid=1.
  - Required: next cycle out_valid=0, imem_addr=RESET_PC, FSM=OP.
